regfile_sb: RTL and testbench

- Parametrised successor to the 8x12 gate-level register file for the scalar pipelined processor.
- One synchronous write port and two gated read ports (port 2 and port 3), with write-through bypass.
- Adds a per-register busy scoreboard: issue reserves a destination, and writeback releases it. The decode stage uses this to detect RAW hazards.
- Sits between decode (read, reserve) and writeback (write).

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_sb_rdport.sv | 44 ++++
 rtl/regfile_sb.sv | 117 +++++++++++
 tb/tb_regfile_sb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and the one-hot address decoder used by the register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 3;

  // Widest address the decoder handles; callers narrow the result with a cast.
  localparam int MAX_ADDR_W = 5;
  localparam int MAX_NREG   = 2 ** MAX_ADDR_W;

  // One-hot decode of a register address (write select, busy set/clear).
  function automatic logic [MAX_NREG-1:0] onehot_dec(input logic [MAX_ADDR_W-1:0] addr);
    logic [MAX_NREG-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// Gated read port: write-through bypass, optional hardwired r0 and busy qualify.
module regfile_sb_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit R0_ZERO = 1'b0,
  localparam int NREG   = 2 ** ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem [NREG],
  input  logic [NREG-1:0]   busy_bits,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic r0_hit;
  logic wr_hit;

  assign r0_hit = R0_ZERO && (addr == '0);
  assign wr_hit = wr_en && (wr_addr == addr);

  // Read mux: disabled port reads 0, same-cycle writeback wins over storage.
  always_comb begin
    data = '0;
    if (en) begin
      if (wr_hit && !r0_hit) begin
        data = wr_data;
      end else if (r0_hit) begin
        data = '0;
      end else begin
        data = mem[addr];
      end
    end
  end

  // A writeback landing this cycle resolves the hazard on that operand.
  assign busy = en && busy_bits[addr] && !wr_hit;

endmodule

// File: rtl/regfile_sb.sv
// Register file with one write port, two gated read ports and a busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit R0_ZERO = 1'b0,
  localparam int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd2_busy,
  input  logic              rd3_en,
  input  logic [ADDR_W-1:0] rd3_addr,
  output logic [DATA_W-1:0] rd3_data,
  output logic              rd3_busy,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  input  logic              flush,
  output logic [NREG-1:0]   busy_vec
);

  logic [DATA_W-1:0] mem_reg [NREG];
  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;
  logic [NREG-1:0]   wr_sel;
  logic [NREG-1:0]   rsv_sel;
  logic [NREG-1:0]   r0_mask;
  logic [NREG-1:0]   wr_mask;
  logic [NREG-1:0]   rsv_set;
  logic              rsv_r0;
  logic              wr_fwd;

  assign wr_sel  = NREG'(onehot_dec(MAX_ADDR_W'(wr_addr)));
  assign rsv_sel = NREG'(onehot_dec(MAX_ADDR_W'(rsv_addr)));
  assign r0_mask = R0_ZERO ? NREG'(1) : '0;

  // Register 0 is never written nor reserved when hardwired to zero.
  assign wr_mask = wr_en ? (wr_sel & ~r0_mask) : '0;

  assign rsv_r0 = R0_ZERO && (rsv_addr == '0);
  assign wr_fwd = wr_en && (wr_addr == rsv_addr);

  // Accept when the destination is free or being released this same cycle;
  // a hardwired r0 is always accepted and never tracked. Held low in reset.
  assign rsv_ok = rst_n && rsv_en &&
                  (rsv_r0 || (!flush && (!busy_reg[rsv_addr] || wr_fwd)));

  assign rsv_set = rsv_ok ? (rsv_sel & ~r0_mask) : '0;

  // Clear-then-set so a same-address reserve and writeback keeps the bit set.
  assign busy_next = flush ? '0 : ((busy_reg & ~(wr_en ? wr_sel : '0)) | rsv_set);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_mem
      // Storage word gi: cleared by reset, loaded on its write select.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (wr_mask[gi]) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

  regfile_sb_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .R0_ZERO(R0_ZERO)
  ) u_rd2 (
    .en       (rd2_en),
    .addr     (rd2_addr),
    .mem      (mem_reg),
    .busy_bits(busy_reg),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .data     (rd2_data),
    .busy     (rd2_busy)
  );

  regfile_sb_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .R0_ZERO(R0_ZERO)
  ) u_rd3 (
    .en       (rd3_en),
    .addr     (rd3_addr),
    .mem      (mem_reg),
    .busy_bits(busy_reg),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .data     (rd3_data),
    .busy     (rd3_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench: default 8x12 instance (a_*) and a 16x16 hardwired-r0 instance (b_*)
// share one stimulus stream and are compared against an array-based model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd2_en;
  logic [3:0]  rd2_addr;
  logic        rd3_en;
  logic [3:0]  rd3_addr;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        flush;

  logic [11:0] a_rd2_data, a_rd3_data;
  logic        a_rd2_busy, a_rd3_busy, a_rsv_ok;
  logic [7:0]  a_busy_vec;
  logic [15:0] b_rd2_data, b_rd3_data;
  logic        b_rd2_busy, b_rd3_busy, b_rsv_ok;
  logic [15:0] b_busy_vec;

  int n_vec = 0;
  int n_err = 0;

  // reference state: [instance][register]
  logic [15:0] mem_m  [2][16];
  bit          busy_m [2][16];

  always #5 clk = ~clk;

  regfile_sb u_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[11:0]),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr[2:0]), .rd2_data(a_rd2_data), .rd2_busy(a_rd2_busy),
    .rd3_en(rd3_en), .rd3_addr(rd3_addr[2:0]), .rd3_data(a_rd3_data), .rd3_busy(a_rd3_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr[2:0]), .rsv_ok(a_rsv_ok),
    .flush(flush), .busy_vec(a_busy_vec)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .R0_ZERO(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(b_rd2_data), .rd2_busy(b_rd2_busy),
    .rd3_en(rd3_en), .rd3_addr(rd3_addr), .rd3_data(b_rd3_data), .rd3_busy(b_rd3_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(b_rsv_ok),
    .flush(flush), .busy_vec(b_busy_vec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nreg(int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic bit r0z(int i);
    return i == 1;
  endfunction

  function automatic logic [15:0] dmask(int i);
    return (i == 0) ? 16'h0FFF : 16'hFFFF;
  endfunction

  function automatic logic [15:0] exp_rd(int i, logic en, logic [3:0] addr);
    int a, wa;
    a  = int'(addr) % nreg(i);
    wa = int'(wr_addr) % nreg(i);
    if (!en) return 16'h0;
    if (wr_en && wa == a && !(r0z(i) && a == 0)) return wr_data & dmask(i);
    if (r0z(i) && a == 0) return 16'h0;
    return mem_m[i][a];
  endfunction

  function automatic logic exp_busy(int i, logic en, logic [3:0] addr);
    int a, wa;
    a  = int'(addr) % nreg(i);
    wa = int'(wr_addr) % nreg(i);
    return en && busy_m[i][a] && !(wr_en && wa == a);
  endfunction

  function automatic logic exp_rsv(int i);
    int ra, wa;
    ra = int'(rsv_addr) % nreg(i);
    wa = int'(wr_addr) % nreg(i);
    if (!rst_n || !rsv_en) return 1'b0;
    if (r0z(i) && ra == 0) return 1'b1;
    if (flush) return 1'b0;
    return !busy_m[i][ra] || (wr_en && wa == ra);
  endfunction

  function automatic logic [15:0] exp_vec(int i);
    logic [15:0] v;
    v = '0;
    for (int j = 0; j < nreg(i); j++) v[j] = busy_m[i][j];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) begin
        mem_m[i][j]  = '0;
        busy_m[i][j] = 1'b0;
      end
  endtask

  task automatic model_update();
    logic ok;
    int   ra, wa;
    for (int i = 0; i < 2; i++) begin
      ok = exp_rsv(i);
      ra = int'(rsv_addr) % nreg(i);
      wa = int'(wr_addr) % nreg(i);
      if (wr_en && !(r0z(i) && wa == 0)) mem_m[i][wa] = wr_data & dmask(i);
      if (flush) begin
        for (int j = 0; j < 16; j++) busy_m[i][j] = 1'b0;
      end else begin
        if (wr_en) busy_m[i][wa] = 1'b0;
        if (ok && !(r0z(i) && ra == 0)) busy_m[i][ra] = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic r2e, input logic [3:0] r2a,
                       input logic r3e, input logic [3:0] r3a,
                       input logic rse, input logic [3:0] rsa, input logic fl);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd2_en = r2e; rd2_addr = r2a; rd3_en = r3e; rd3_addr = r3a;
    rsv_en = rse; rsv_addr = rsa; flush = fl;
  endtask

  task automatic check_all();
    #1;
    chk("a_rd2_data", 32'(a_rd2_data), 32'(exp_rd(0, rd2_en, rd2_addr)));
    chk("a_rd3_data", 32'(a_rd3_data), 32'(exp_rd(0, rd3_en, rd3_addr)));
    chk("a_rd2_busy", 32'(a_rd2_busy), 32'(exp_busy(0, rd2_en, rd2_addr)));
    chk("a_rd3_busy", 32'(a_rd3_busy), 32'(exp_busy(0, rd3_en, rd3_addr)));
    chk("a_rsv_ok",   32'(a_rsv_ok),   32'(exp_rsv(0)));
    chk("a_busy_vec", 32'(a_busy_vec), 32'(exp_vec(0)));
    chk("b_rd2_data", 32'(b_rd2_data), 32'(exp_rd(1, rd2_en, rd2_addr)));
    chk("b_rd3_data", 32'(b_rd3_data), 32'(exp_rd(1, rd3_en, rd3_addr)));
    chk("b_rd2_busy", 32'(b_rd2_busy), 32'(exp_busy(1, rd2_en, rd2_addr)));
    chk("b_rd3_busy", 32'(b_rd3_busy), 32'(exp_busy(1, rd3_en, rd3_addr)));
    chk("b_rsv_ok",   32'(b_rsv_ok),   32'(exp_rsv(1)));
    chk("b_busy_vec", 32'(b_busy_vec), 32'(exp_vec(1)));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // after reset every register reads zero, nothing busy
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 1, 4'(k), 1, 4'(7 - k), 0, 0, 0);
      check_all();
      chk("rst_rd2", 32'(a_rd2_data), 32'h0);
      step();
    end
    chk("rst_vec", 32'(a_busy_vec), 32'h0);

    // write then read back on both ports
    drive(1, 5, 16'h0ABC, 0, 0, 0, 0, 0, 0, 0); check_all(); step();
    drive(0, 0, 0, 1, 5, 1, 5, 0, 0, 0); check_all();
    chk("r5_p2", 32'(a_rd2_data), 32'hABC);
    chk("r5_p3", 32'(a_rd3_data), 32'hABC);
    step();

    // same-cycle bypass
    drive(1, 6, 16'h0123, 0, 0, 1, 6, 0, 0, 0); check_all();
    chk("byp_r6", 32'(a_rd3_data), 32'h123);
    step();

    // reserve r3, re-reserve rejected, writeback releases
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0); check_all();
    chk("rsv3_ok", 32'(a_rsv_ok), 32'h1);
    step();
    drive(0, 0, 0, 1, 3, 0, 0, 1, 3, 0); check_all();
    chk("busy3_vec", 32'(a_busy_vec), 32'h08);
    chk("busy3_rd2", 32'(a_rd2_busy), 32'h1);
    chk("rsv3_again", 32'(a_rsv_ok), 32'h0);
    step();
    drive(1, 3, 16'h0055, 1, 3, 0, 0, 0, 0, 0); check_all();
    chk("wb3_busy", 32'(a_rd2_busy), 32'h0);
    chk("wb3_data", 32'(a_rd2_data), 32'h055);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_all();
    chk("busy3_clr", 32'(a_busy_vec), 32'h0);
    step();

    // reserve + writeback same register keeps it busy; flush clears, data still lands
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0); check_all(); step();
    drive(1, 4, 16'h0777, 0, 0, 0, 0, 1, 4, 0); check_all();
    chk("rw4_ok", 32'(a_rsv_ok), 32'h1);
    step();
    drive(0, 0, 0, 1, 4, 0, 0, 0, 0, 0); check_all();
    chk("rw4_busy", 32'(a_busy_vec[4]), 32'h1);
    step();
    drive(1, 4, 16'h0999, 0, 0, 0, 0, 0, 0, 1); check_all(); step();
    drive(0, 0, 0, 1, 4, 0, 0, 0, 0, 0); check_all();
    chk("flush_vec", 32'(a_busy_vec), 32'h0);
    chk("flush_data", 32'(a_rd2_data), 32'h999);
    step();

    // hardwired r0 on the 16x16 instance
    drive(1, 0, 16'h0FFF, 1, 0, 0, 0, 1, 0, 0); check_all();
    chk("r0_rsv_ok", 32'(b_rsv_ok), 32'h1);
    chk("r0_byp", 32'(b_rd2_data), 32'h0);
    step();
    drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 0); check_all();
    chk("r0_rd", 32'(b_rd2_data), 32'h0);
    chk("r0_busy", 32'(b_busy_vec[0]), 32'h0);
    step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), 4'($urandom), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 4'($urandom),
            1'($urandom_range(0, 3) != 0), 4'($urandom),
            1'($urandom), 4'($urandom), 1'($urandom_range(0, 15) == 0));
      check_all();
      step();
    end

    // fill some data, then reserve everything
    for (int k = 0; k < 16; k++) begin
      drive(1, 4'(k), 16'(16'h1111 * (k + 1)), 0, 0, 0, 0, 0, 0, k == 0);
      check_all();
      step();
    end
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 4'(k), 0);
      check_all();
      step();
    end
    drive(0, 0, 0, 1, 2, 1, 9, 0, 0, 0); check_all();
    chk("full_vec_a", 32'(a_busy_vec), 32'hFF);
    chk("full_vec_b", 32'(b_busy_vec), 32'hFFFE);

    // reset asserted mid-cycle clears everything immediately
    #2;
    rst_n = 1'b0;
    model_reset();
    check_all();
    chk("mrst_vec_a", 32'(a_busy_vec), 32'h0);
    chk("mrst_vec_b", 32'(b_busy_vec), 32'h0);
    for (int k = 0; k < 16; k++) begin
      rd2_addr = 4'(k);
      rd3_addr = 4'(15 - k);
      rsv_en   = 1'b1;
      rsv_addr = 4'(k);
      check_all();
      chk("mrst_rd_b", 32'(b_rd2_data), 32'h0);
    end
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 1, 1, 2, 0, 0, 0); check_all(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
